// File: rtl/ex_branch_resolve_if.sv
// Shared op encoding plus the EX-stage bundle between the ID/EX register, EX/MEM register and IF.
// Optional BRANCH_STATS_EN adds the stat_branches / stat_mispredicts counters.
package ex_branch_resolve_pkg;
  typedef enum logic [5:0] {
    OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } op_e;
endpackage

interface ex_branch_resolve_if;
  import ex_branch_resolve_pkg::*;
  logic        rdy;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  op_e         ex_op;
  logic        pred_jump_or_not;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o;
  logic [31:0] rd_data_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  op_e         op_o;
  logic        failed;
  logic [31:0] jump_target;
  logic [31:0] if_pc;
  logic        if_pred_jump;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output rdy, ex_stall, ex_pc, ex_reg1, ex_reg2, ex_imm, ex_rd, ex_op, pred_jump_or_not, if_pc,
    input  rd_addr_o, rd_we_o, rd_data_o, mem_addr_o, mem_wdata_o, op_o, failed, jump_target,
           if_pred_jump, stat_branches, stat_mispredicts
  );
  modport slave (
    input  rdy, ex_stall, ex_pc, ex_reg1, ex_reg2, ex_imm, ex_rd, ex_op, pred_jump_or_not, if_pc,
    output rd_addr_o, rd_we_o, rd_data_o, mem_addr_o, mem_wdata_o, op_o, failed, jump_target,
           if_pred_jump, stat_branches, stat_mispredicts
  );
`else
  modport master (
    output rdy, ex_stall, ex_pc, ex_reg1, ex_reg2, ex_imm, ex_rd, ex_op, pred_jump_or_not, if_pc,
    input  rd_addr_o, rd_we_o, rd_data_o, mem_addr_o, mem_wdata_o, op_o, failed, jump_target,
           if_pred_jump
  );
  modport slave (
    input  rdy, ex_stall, ex_pc, ex_reg1, ex_reg2, ex_imm, ex_rd, ex_op, pred_jump_or_not, if_pc,
    output rd_addr_o, rd_we_o, rd_data_o, mem_addr_o, mem_wdata_o, op_o, failed, jump_target,
           if_pred_jump
  );
`endif
endinterface

// File: rtl/ex_branch_resolve.sv
// Execute stage: ALU, load/store address, branch/JALR resolution and the 2-bit BHT.
// Define BRANCH_STATS_EN to add branch / mispredict counters.
module ex_branch_resolve
  import ex_branch_resolve_pkg::*;
#(
  parameter int         BHT_IDX_W = 7,
  parameter logic [1:0] BHT_INIT  = 2'b01
) (
  input logic clk,
  input logic rst,
  ex_branch_resolve_if.slave bus
);
  localparam int BHT_SIZE = 1 << BHT_IDX_W;

  logic [1:0] bht [BHT_SIZE];
  logic [BHT_IDX_W-1:0] ex_idx, if_idx;
  logic        has_rd, is_branch, is_jalr, taken, resolve_fail, advance;
  logic [31:0] rd_data, mem_addr, mem_wdata, jump_target;
  logic [31:0] r1, r2, imm, pc;
  logic        unused_if_pc_bits;

  assign r1  = bus.ex_reg1;
  assign r2  = bus.ex_reg2;
  assign imm = bus.ex_imm;
  assign pc  = bus.ex_pc;
  assign ex_idx = bus.ex_pc[BHT_IDX_W+1:2];
  assign if_idx = bus.if_pc[BHT_IDX_W+1:2];
  assign unused_if_pc_bits = ^{bus.if_pc[31:BHT_IDX_W+2], bus.if_pc[1:0]};

  always_comb begin
    has_rd      = 1'b0;
    is_branch   = 1'b0;
    is_jalr     = 1'b0;
    taken       = 1'b0;
    rd_data     = 32'h0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    jump_target = 32'h0;
    case (bus.ex_op)
      OP_LUI:   begin has_rd = 1'b1; rd_data = imm; end
      OP_AUIPC: begin has_rd = 1'b1; rd_data = pc + imm; end
      OP_JAL:   begin has_rd = 1'b1; rd_data = pc + 32'd4; end
      OP_JALR:  begin
        has_rd = 1'b1; is_jalr = 1'b1; rd_data = pc + 32'd4;
        jump_target = (r1 + imm) & ~32'h1;
      end
      OP_BEQ:   begin is_branch = 1'b1; taken = (r1 == r2); end
      OP_BNE:   begin is_branch = 1'b1; taken = (r1 != r2); end
      OP_BLT:   begin is_branch = 1'b1; taken = ($signed(r1) < $signed(r2)); end
      OP_BGE:   begin is_branch = 1'b1; taken = ($signed(r1) >= $signed(r2)); end
      OP_BLTU:  begin is_branch = 1'b1; taken = (r1 < r2); end
      OP_BGEU:  begin is_branch = 1'b1; taken = (r1 >= r2); end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin has_rd = 1'b1; mem_addr = r1 + imm; end
      OP_SB, OP_SH, OP_SW: begin mem_addr = r1 + imm; mem_wdata = r2; end
      OP_ADDI:  begin has_rd = 1'b1; rd_data = r1 + imm; end
      OP_SLTI:  begin has_rd = 1'b1; rd_data = {31'h0, $signed(r1) < $signed(imm)}; end
      OP_SLTIU: begin has_rd = 1'b1; rd_data = {31'h0, r1 < imm}; end
      OP_XORI:  begin has_rd = 1'b1; rd_data = r1 ^ imm; end
      OP_ORI:   begin has_rd = 1'b1; rd_data = r1 | imm; end
      OP_ANDI:  begin has_rd = 1'b1; rd_data = r1 & imm; end
      OP_SLLI:  begin has_rd = 1'b1; rd_data = r1 << imm[4:0]; end
      OP_SRLI:  begin has_rd = 1'b1; rd_data = r1 >> imm[4:0]; end
      OP_SRAI:  begin has_rd = 1'b1; rd_data = $signed(r1) >>> imm[4:0]; end
      OP_ADD:   begin has_rd = 1'b1; rd_data = r1 + r2; end
      OP_SUB:   begin has_rd = 1'b1; rd_data = r1 - r2; end
      OP_SLL:   begin has_rd = 1'b1; rd_data = r1 << r2[4:0]; end
      OP_SLT:   begin has_rd = 1'b1; rd_data = {31'h0, $signed(r1) < $signed(r2)}; end
      OP_SLTU:  begin has_rd = 1'b1; rd_data = {31'h0, r1 < r2}; end
      OP_XOR:   begin has_rd = 1'b1; rd_data = r1 ^ r2; end
      OP_SRL:   begin has_rd = 1'b1; rd_data = r1 >> r2[4:0]; end
      OP_SRA:   begin has_rd = 1'b1; rd_data = $signed(r1) >>> r2[4:0]; end
      OP_OR:    begin has_rd = 1'b1; rd_data = r1 | r2; end
      OP_AND:   begin has_rd = 1'b1; rd_data = r1 & r2; end
      default:  ;
    endcase
    if (is_branch) jump_target = taken ? (pc + imm) : (pc + 32'd4);
  end

  // The instruction only resolves on the cycle it actually leaves EX.
  assign advance      = bus.rdy && !bus.ex_stall;
  assign resolve_fail = is_branch ? (taken != bus.pred_jump_or_not) : is_jalr;

  assign bus.failed       = resolve_fail && advance && !rst;
  assign bus.jump_target  = jump_target;
  assign bus.rd_we_o      = has_rd && (bus.ex_rd != 5'd0);
  assign bus.rd_addr_o    = has_rd ? bus.ex_rd : 5'd0;
  assign bus.rd_data_o    = rd_data;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_wdata_o  = mem_wdata;
  assign bus.op_o         = bus.ex_op;
  assign bus.if_pred_jump = bht[if_idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_SIZE; i++) bht[i] <= BHT_INIT;
    end else if (advance && is_branch) begin
      if (taken && bht[ex_idx] != 2'b11)
        bht[ex_idx] <= bht[ex_idx] + 2'd1;
      else if (!taken && bht[ex_idx] != 2'b00)
        bht[ex_idx] <= bht[ex_idx] - 2'd1;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= 32'h0;
      stat_mispredicts <= 32'h0;
    end else if (advance) begin
      if (is_branch || is_jalr) stat_branches <= stat_branches + 32'd1;
      if (bus.failed) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

  assign bus.stat_branches    = stat_branches;
  assign bus.stat_mispredicts = stat_mispredicts;
`endif
endmodule

// File: tb/tb_ex_branch_resolve.sv
// Scoreboard bench for ex_branch_resolve: expected EX outputs queued at drive time, popped at negedge.
module tb_ex_branch_resolve;
  import ex_branch_resolve_pkg::*;

  typedef struct packed {
    logic        we;
    logic [4:0]  ra;
    logic [31:0] rdat;
    logic [31:0] maddr;
    logic [31:0] mwdat;
    logic        fail;
    logic [31:0] jt;
    logic [5:0]  op;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  out_t sb[$];
  out_t obs, exp_o;

  ex_branch_resolve_if bus();

  ex_branch_resolve #(.BHT_IDX_W(7), .BHT_INIT(2'b01)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.rd_we_o, bus.rd_addr_o, bus.rd_data_o, bus.mem_addr_o, bus.mem_wdata_o,
                bus.failed, bus.jump_target, bus.op_o};

  function automatic out_t mk(logic we, logic [4:0] ra, logic [31:0] rdat, logic [31:0] ma,
                              logic [31:0] mw, logic f, logic [31:0] jt, op_e op);
    return {we, ra, rdat, ma, mw, f, jt, op};
  endfunction

  task automatic applyStimulus(op_e op, logic [31:0] pc, logic [31:0] r1, logic [31:0] r2,
                               logic [31:0] imm, logic [4:0] rd, logic pred, out_t e);
    bus.ex_op = op; bus.ex_pc = pc; bus.ex_reg1 = r1; bus.ex_reg2 = r2;
    bus.ex_imm = imm; bus.ex_rd = rd; bus.pred_jump_or_not = pred;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.if_pc = 32'h100;
    applyStimulus(OP_BEQ, 32'h100, 5, 5, 32'h20, 5'd3, 1'b0, mk(0, 0, 0, 0, 0, 0, 32'h120, OP_BEQ));
    @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL reset_gates_failed: got %h want %h", obs, exp_o); end
    n_cmp++;
    if (bus.if_pred_jump !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_pred_100: got %b want 0", bus.if_pred_jump); end
    bus.if_pc = 32'h1FC; #1; n_cmp++;
    if (bus.if_pred_jump !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_pred_1fc: got %b want 0", bus.if_pred_jump); end
    applyStimulus(OP_NOP, 32'h44, 32'h1234, 32'h5678, 32'h9, 5'd7, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, OP_NOP));
    @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL nop_outputs: got %h want %h", obs, exp_o); end
    step(); rst = 1'b0;
  endtask

  task automatic test_bht_training();
    logic exp_pred [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bus.if_pc = 32'h100;
    for (int i = 0; i < 6; i++) begin
      if (i == 0)
        applyStimulus(OP_BEQ, 32'h100, 5, 5, 32'h20, 5'd0, 1'b0, mk(0, 0, 0, 0, 0, 1, 32'h120, OP_BEQ));
      else if (i < 4)
        applyStimulus(OP_BEQ, 32'h100, 5, 5, 32'h20, 5'd0, 1'b1, mk(0, 0, 0, 0, 0, 0, 32'h120, OP_BEQ));
      else
        applyStimulus(OP_BEQ, 32'h100, 5, 6, 32'h20, 5'd0, 1'b1, mk(0, 0, 0, 0, 0, 1, 32'h104, OP_BEQ));
      @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
      if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL beq_train_%0d: got %h want %h", i, obs, exp_o); end
      step(); n_cmp++;
      if (bus.if_pred_jump !== exp_pred[i]) begin
        n_bad++; $display("[TB] FAIL bht_pred_%0d: got %b want %b", i, bus.if_pred_jump, exp_pred[i]);
      end
`ifdef BRANCH_STATS_EN
      if (i == 4) begin
        n_cmp++;
        if (bus.stat_branches !== 32'd5 || bus.stat_mispredicts !== 32'd2) begin
          n_bad++; $display("[TB] FAIL stats: got %0d/%0d want 5/2", bus.stat_branches, bus.stat_mispredicts);
        end
      end
`endif
    end
  endtask

  task automatic test_compare_ops();
    bus.if_pc = 32'h200;
    applyStimulus(OP_BLT, 32'h200, 32'hFFFFFFFF, 1, 32'h40, 5'd0, 1'b1, mk(0, 0, 0, 0, 0, 0, 32'h240, OP_BLT));
    @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL blt_signed: got %h want %h", obs, exp_o); end
    step(); n_cmp++;
    if (bus.if_pred_jump !== 1'b1) begin n_bad++; $display("[TB] FAIL blt_pred: got %b want 1", bus.if_pred_jump); end
    applyStimulus(OP_BLTU, 32'h200, 32'hFFFFFFFF, 1, 32'h40, 5'd0, 1'b1, mk(0, 0, 0, 0, 0, 1, 32'h204, OP_BLTU));
    @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL bltu_unsigned: got %h want %h", obs, exp_o); end
    step(); n_cmp++;
    if (bus.if_pred_jump !== 1'b0) begin n_bad++; $display("[TB] FAIL bltu_pred: got %b want 0", bus.if_pred_jump); end
    applyStimulus(OP_BNE, 32'h208, 3, 3, 32'h10, 5'd0, 1'b0, mk(0, 0, 0, 0, 0, 0, 32'h20C, OP_BNE));
    @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL bne: got %h want %h", obs, exp_o); end
    step();
    applyStimulus(OP_BGE, 32'h208, 1, 32'hFFFFFFFF, 32'h10, 5'd0, 1'b0, mk(0, 0, 0, 0, 0, 1, 32'h218, OP_BGE));
    @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL bge_signed: got %h want %h", obs, exp_o); end
    step();
    applyStimulus(OP_BGEU, 32'h208, 1, 32'hFFFFFFFF, 32'h10, 5'd0, 1'b1, mk(0, 0, 0, 0, 0, 1, 32'h20C, OP_BGEU));
    @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL bgeu_unsigned: got %h want %h", obs, exp_o); end
    step();
  endtask

  task automatic test_jumps();
    bus.if_pc = 32'h500;
    applyStimulus(OP_JALR, 32'h500, 32'h1003, 0, 0, 5'd1, 1'b0, mk(1, 1, 32'h504, 0, 0, 1, 32'h1002, OP_JALR));
    @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL jalr: got %h want %h", obs, exp_o); end
    step(); n_cmp++;
    if (bus.if_pred_jump !== 1'b0) begin n_bad++; $display("[TB] FAIL jalr_no_train: got %b want 0", bus.if_pred_jump); end
    bus.if_pc = 32'h100;
    applyStimulus(OP_JAL, 32'h100, 0, 0, 32'h80, 5'd1, 1'b1, mk(1, 1, 32'h104, 0, 0, 0, 0, OP_JAL));
    @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL jal: got %h want %h", obs, exp_o); end
    step(); n_cmp++;
    if (bus.if_pred_jump !== 1'b0) begin n_bad++; $display("[TB] FAIL jal_no_train: got %b want 0", bus.if_pred_jump); end
  endtask

  task automatic test_stall();
    bus.if_pc = 32'h10C;
    bus.ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_BEQ, 32'h10C, 9, 9, 32'h40, 5'd0, 1'b0, mk(0, 0, 0, 0, 0, 0, 32'h14C, OP_BEQ));
      @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
      if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL stall_hold_%0d: got %h want %h", i, obs, exp_o); end
      step(); n_cmp++;
      if (bus.if_pred_jump !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_no_train_%0d: got %b want 0", i, bus.if_pred_jump); end
    end
    bus.ex_stall = 1'b0;
    applyStimulus(OP_BEQ, 32'h10C, 9, 9, 32'h40, 5'd0, 1'b0, mk(0, 0, 0, 0, 0, 1, 32'h14C, OP_BEQ));
    @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL stall_release: got %h want %h", obs, exp_o); end
    step(); n_cmp++;
    if (bus.if_pred_jump !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_release_pred: got %b want 1", bus.if_pred_jump); end
    applyStimulus(OP_BEQ, 32'h10C, 9, 10, 32'h40, 5'd0, 1'b1, mk(0, 0, 0, 0, 0, 1, 32'h110, OP_BEQ));
    @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL after_stall_nt: got %h want %h", obs, exp_o); end
    step(); n_cmp++;
    if (bus.if_pred_jump !== 1'b0) begin n_bad++; $display("[TB] FAIL single_update: got %b want 0", bus.if_pred_jump); end
    applyStimulus(OP_BEQ, 32'h10C, 9, 9, 32'h40, 5'd0, 1'b0, mk(0, 0, 0, 0, 0, 1, 32'h14C, OP_BEQ));
    step();
    void'(sb.pop_front());
    bus.rdy = 1'b0;
    applyStimulus(OP_BEQ, 32'h10C, 9, 10, 32'h40, 5'd0, 1'b1, mk(0, 0, 0, 0, 0, 0, 32'h110, OP_BEQ));
    @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL rdy_low_gate: got %h want %h", obs, exp_o); end
    step(); n_cmp++;
    if (bus.if_pred_jump !== 1'b1) begin n_bad++; $display("[TB] FAIL rdy_low_no_train: got %b want 1", bus.if_pred_jump); end
    bus.rdy = 1'b1;
    bus.ex_stall = 1'b1;
    applyStimulus(OP_BEQ, 32'h10C, 9, 9, 32'h40, 5'd0, 1'b0, mk(0, 0, 0, 0, 0, 0, 32'h14C, OP_BEQ));
    @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL stall_before_rst: got %h want %h", obs, exp_o); end
    #1 rst = 1'b1;
    #1 n_cmp++;
    if (bus.if_pred_jump !== 1'b0) begin n_bad++; $display("[TB] FAIL async_rst_bht: got %b want 0", bus.if_pred_jump); end
    rst = 1'b0;
    step();
    bus.ex_stall = 1'b0;
    applyStimulus(OP_BEQ, 32'h10C, 9, 9, 32'h40, 5'd0, 1'b0, mk(0, 0, 0, 0, 0, 1, 32'h14C, OP_BEQ));
    @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL post_rst_release: got %h want %h", obs, exp_o); end
    step(); n_cmp++;
    if (bus.if_pred_jump !== 1'b1) begin n_bad++; $display("[TB] FAIL post_rst_train: got %b want 1", bus.if_pred_jump); end
  endtask

  task automatic test_alu();
    applyStimulus(OP_ADDI,  32'h0,    1,            0,           7,            5'd0, 1'b0, mk(0, 0, 8, 0, 0, 0, 0, OP_ADDI));
    applyStimulus(OP_SRA,   32'h0,    32'h80000000, 32'h24,      0,            5'd5, 1'b0, mk(1, 5, 32'hF8000000, 0, 0, 0, 0, OP_SRA));
    applyStimulus(OP_SLT,   32'h0,    32'hFFFFFFFF, 1,           0,            5'd2, 1'b0, mk(1, 2, 1, 0, 0, 0, 0, OP_SLT));
    applyStimulus(OP_SLTU,  32'h0,    32'hFFFFFFFF, 1,           0,            5'd2, 1'b0, mk(1, 2, 0, 0, 0, 0, 0, OP_SLTU));
    applyStimulus(OP_SUB,   32'h0,    3,            5,           0,            5'd3, 1'b0, mk(1, 3, 32'hFFFFFFFE, 0, 0, 0, 0, OP_SUB));
    applyStimulus(OP_ADD,   32'h0,    32'hFFFFFFFF, 2,           0,            5'd3, 1'b0, mk(1, 3, 1, 0, 0, 0, 0, OP_ADD));
    applyStimulus(OP_SRLI,  32'h0,    32'h80000000, 0,           32'h21,       5'd4, 1'b0, mk(1, 4, 32'h40000000, 0, 0, 0, 0, OP_SRLI));
    applyStimulus(OP_LUI,   32'h0,    0,            0,           32'h12345000, 5'd6, 1'b0, mk(1, 6, 32'h12345000, 0, 0, 0, 0, OP_LUI));
    applyStimulus(OP_AUIPC, 32'h1000, 0,            0,           32'h2000,     5'd6, 1'b0, mk(1, 6, 32'h3000, 0, 0, 0, 0, OP_AUIPC));
    applyStimulus(OP_LW,    32'h0,    32'h100,      0,           8,            5'd7, 1'b0, mk(1, 7, 0, 32'h108, 0, 0, 0, OP_LW));
    applyStimulus(OP_SW,    32'h0,    32'h100,      32'hDEAD,    32'hFFFFFFFC, 5'd9, 1'b0, mk(0, 0, 0, 32'hFC, 32'hDEAD, 0, 0, OP_SW));
    applyStimulus(OP_XORI,  32'h0,    32'hF0F0,     0,           32'hFFFF,     5'd1, 1'b0, mk(1, 1, 32'h0F0F, 0, 0, 0, 0, OP_XORI));
    bus.ex_op = OP_NOP;
  endtask

  // ALU vectors are all queued up front, then replayed one per cycle against the scoreboard.
  task automatic checkOutput_alu();
    out_t vec[$];
    op_e  ops[$];
    logic [31:0] a[$], b[$], im[$], pcs[$];
    logic [4:0]  rds[$];
    vec = sb; sb.delete();
    ops = '{OP_ADDI, OP_SRA, OP_SLT, OP_SLTU, OP_SUB, OP_ADD, OP_SRLI, OP_LUI, OP_AUIPC, OP_LW, OP_SW, OP_XORI};
    a   = '{1, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 32'hFFFFFFFF, 32'h80000000, 0, 0, 32'h100, 32'h100, 32'hF0F0};
    b   = '{0, 32'h24, 1, 1, 5, 2, 0, 0, 0, 0, 32'hDEAD, 0};
    im  = '{7, 0, 0, 0, 0, 0, 32'h21, 32'h12345000, 32'h2000, 8, 32'hFFFFFFFC, 32'hFFFF};
    pcs = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 0, 0, 0};
    rds = '{0, 5, 2, 2, 3, 3, 4, 6, 6, 7, 9, 1};
    for (int i = 0; i < vec.size(); i++) begin
      applyStimulus(ops[i], pcs[i], a[i], b[i], im[i], rds[i], 1'b0, vec[i]);
      @(negedge clk); exp_o = sb.pop_front(); n_cmp++;
      if (obs !== exp_o) begin n_bad++; $display("[TB] FAIL alu_%0d: got %h want %h", i, obs, exp_o); end
      step();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.rdy = 1'b1; bus.ex_stall = 1'b0; bus.if_pc = 32'h0;
    bus.ex_op = OP_NOP; bus.ex_pc = 0; bus.ex_reg1 = 0; bus.ex_reg2 = 0;
    bus.ex_imm = 0; bus.ex_rd = 0; bus.pred_jump_or_not = 1'b0;
    #1;
    test_reset();
    test_bht_training();
    test_compare_ops();
    test_jumps();
    test_stall();
    test_alu();
    checkOutput_alu();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_branch_resolve.md
Name: ex_branch_resolve

Overview:
- Execute stage, directly downstream of the ID/EX pipeline register.
- Computes ALU results and load/store addresses for the EX/MEM register.
- Resolves conditional branches and JALR, and raises the misprediction flush (`failed`) with a redirect target.
- Owns the 2-bit branch history table (BHT). IF reads the BHT combinationally; EX trains it at resolution.

Parameters:
BHT_IDX_W, 7, BHT index width; 2^BHT_IDX_W entries indexed by pc[BHT_IDX_W+1:2]
BHT_INIT, 2'b01, reset value of every counter (weakly not-taken)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
rdy  input  1  global ready; no state changes when low
ex_stall  input  1  EX held (same stall that freezes ID/EX); blocks training and flush
ex_pc  input  `AddrLen  instruction PC
ex_reg1  input  `RegLen  rs1 value
ex_reg2  input  `RegLen  rs2 value
ex_imm  input  `RegLen  sign-extended immediate
ex_rd  input  `RegAddrLen  destination register
ex_op  input  `OpLen  decoded op (config.v op macros)
pred_jump_or_not  input  1  IF's prediction carried with the instruction
rd_addr_o  output  `RegAddrLen  destination to EX/MEM
rd_we_o  output  1  register write enable
rd_data_o  output  `RegLen  ALU result / link address
mem_addr_o  output  `AddrLen  reg1+imm for loads/stores
mem_wdata_o  output  `RegLen  reg2 for stores
op_o  output  `OpLen  op forwarded to MEM
failed  output  1  misprediction; flushes IF/ID and ID/EX
jump_target  output  `AddrLen  redirect PC, valid with failed
if_pc  input  `AddrLen  PC IF is fetching
if_pred_jump  output  1  BHT prediction for if_pc

Behaviour:
- Datapath outputs are combinational from the ex_* inputs.
- NOP gives: rd_we_o=0, rd_addr_o=0, rd_data_o=0, mem_addr_o=0, mem_wdata_o=0, op_o=NOP, failed=0, jump_target=0.
- ALU: all arithmetic is mod 2^32.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
  - Shift amount is operand[4:0]; SRA/SRAI sign-fill.
- rd_we_o = 1 for every op with an rd, except when ex_rd==0; then rd_we_o=0.
- Branches/stores write no register.
- JAL/JALR: rd_data_o = ex_pc+4.
- LUI: rd_data_o = imm. AUIPC: rd_data_o = pc+imm.
- Conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU): actual = comparison result.
  - Mismatch with pred_jump_or_not sets failed=1.
  - jump_target = pc+imm if actual taken, else pc+4.
- JALR: failed=1 always; jump_target = (reg1+imm) & ~32'h1.
- JAL: resolved in IF; failed=0.
- Gating: failed is forced to 0 when rst, !rdy or ex_stall. Resolution takes effect only on the cycle the instruction leaves EX.
- BHT: 2^BHT_IDX_W entries × 2-bit saturating counters. if_pred_jump = counter[1] of entry at if_pc index, combinational.
- Training: on posedge clk with rdy && !ex_stall and a conditional-branch op:
  - taken: counter = min(counter+1, 3).
  - not taken: counter = max(counter-1, 0).
  - Exactly one update per branch; a stalled branch never updates twice.
- Non-branch ops and NOP never touch the BHT.
- Read/update same index in the same cycle: the read returns the pre-update value; no bypass.
- Async reset: all counters go to BHT_INIT immediately, mid-operation included. The next rising edge after deassertion is the first legal update.
- No other internal state.

Optional Feature:
BRANCH_STATS_EN:
- Defined: two 32-bit counters, stat_branches and stat_mispredicts, plus output ports of the same names.
- Counters increment under the same gating as BHT training.
  - stat_branches counts every conditional branch and JALR.
  - stat_mispredicts counts every cycle failed=1.
- Counters wrap at 2^32 and reset asynchronously to 0.
- Undefined: neither the counters nor the ports exist; behaviour is otherwise identical.

Test Plan:
1. Reset, then read if_pc=0x100 and 0x1FC → if_pred_jump=0. Entries index 64 and 127 read 2'b01.
2. BEQ pc=0x100, reg1=reg2=5, imm=0x20, pred=0 → failed=1, jump_target=0x120. Next cycle, if_pc=0x100 predicts 1 (counter 2'b10).
3. Same BEQ repeated 3 more times with pred=1 → failed=0 each time; counter saturates at 3. Then reg2=6 with pred=1 → failed=1, jump_target=0x104, counter=2.
4. BLT reg1=0xFFFFFFFF, reg2=1 → taken; BLTU with the same operands → not taken. JALR reg1=0x1003, imm=0 → failed=1, target=0x1002, rd_data_o=pc+4.
5. Branch held with ex_stall=1 for 3 cycles, then released → failed low during the stall, pulses exactly once on release, counter changes by exactly 1. Async rst pulse mid-stall → counter returns to 2'b01.
6. ADDI rd=0, imm=7 → rd_we_o=0. SRA reg1=0x80000000, reg2=0x24 → rd_data_o=0xF8000000. With BRANCH_STATS_EN, after tests 2-3 → stat_branches=5, stat_mispredicts=2.
